// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative HI/LO multiply/divide unit for a MIPS-style integer pipeline.
// One operation at a time: an accepted start runs WIDTH shift iterations
// (radix-2 shift-add multiply or radix-2 restoring divide on operand
// magnitudes), then a fix-up cycle restores signs and writes HI/LO.
// Latency from the start edge to the HI/LO write is WIDTH+1 edges; done
// pulses for the cycle after that write.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        asynchronous, active-high reset
//   start        request a new operation (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we MTHI/MTLO write enables (honoured only in IDLE)
//   wd           MTHI/MTLO write data
//   busy         high whenever the sequencer is not IDLE
//   done         one-cycle pulse after HI/LO receive a result
//   hi, lo       architectural HI/LO registers
//   div_by_zero  pulses with done when a divide had a zero divisor
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 signed_q, signed_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 b_zero_q, b_zero_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     m_q,      m_d;
  // Shared working register.
  //   multiply: {partial product upper half, remaining multiplier bits}
  //   divide:   {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [WIDTH-1:0]     hi_q,     hi_d;
  logic [WIDTH-1:0]     lo_q,     lo_d;
  logic                 done_q,   done_d;
  logic                 dbz_q,    dbz_d;

  // ---------------------------------------------------------------------------
  // Operand decode at the accepting edge
  // ---------------------------------------------------------------------------
  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  // -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude.
  assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  // ---------------------------------------------------------------------------
  // One multiply iteration: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // One restoring-divide iteration: shift the next dividend bit into the
  // partial remainder, subtract the divisor if it fits, and shift the
  // resulting quotient bit into the low end.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // ---------------------------------------------------------------------------
  // Sign fix-up applied in FIN
  // ---------------------------------------------------------------------------
  logic               neg_result;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;

  assign neg_result = signed_q & (sign_a_q ^ sign_b_q);
  assign prod_res   = neg_result ? -acc_q : acc_q;
  assign quot_raw   = acc_q[WIDTH-1:0];
  assign rem_raw    = acc_q[2*WIDTH-1:WIDTH];
  // Quotient takes the XOR of operand signs; remainder follows the dividend.
  assign quot_res   = neg_result ? -quot_raw : quot_raw;
  assign rem_res    = (signed_q & sign_a_q) ? -rem_raw : rem_raw;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    m_d      = m_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // MTHI/MTLO land at this edge even if an operation is accepted too;
        // that operation's result overwrites them later.
        if (hi_we) hi_d = wd;
        if (lo_we) lo_d = wd;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = op_div;
          signed_d = op_signed;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          b_zero_d = (b == '0);
          m_d      = op_div ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d  = '0;
          lo_d  = '0;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_res;
          lo_d = quot_res;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed-vector bench for muldiv_sequencer at WIDTH=32. Inputs are driven
// at negedges (or just after posedges); outputs are sampled at negedges.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wd;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wd          (wd),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Issues one operation starting at the current negedge and waits for done.
  // Returns at the negedge inside the done cycle. Operands are scrambled right
  // after the accepting edge, since they must not matter afterwards.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, output int edges,
                        output int busy_cnt, output logic dbz_at_done,
                        output int dbz_stray);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clock);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    @(negedge clock);
    busy_cnt  = busy ? 1 : 0;
    dbz_stray = div_by_zero ? 1 : 0;
    edges     = 0;
    while (!done && edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (busy) busy_cnt++;
      if (!done && div_by_zero) dbz_stray++;
    end
    dbz_at_done = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    #1;
    checks++; if (hi !== '0)         begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)         begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    // start held high across several edges under reset must be ignored
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_start_ignored busy=%b exp=0", busy); end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5_A5A5;
    @(posedge clock);
    #1;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    @(negedge clock);
    checks++; if (hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mthi got=%h exp=a5a5a5a5", hi); end
    checks++; if (lo !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mtlo got=%h exp=a5a5a5a5", lo); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)        begin failures++; $display("FAIL mthi_done got=%b exp=0", done); end
    // HI alone; LO must hold
    hi_we = 1'b1; wd = 32'h1111_2222;
    @(posedge clock);
    #1;
    hi_we = 1'b0; wd = '0;
    @(negedge clock);
    checks++; if (hi !== 32'h1111_2222) begin failures++; $display("FAIL mthi_only_hi got=%h exp=11112222", hi); end
    checks++; if (lo !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mthi_only_lo got=%h exp=a5a5a5a5", lo); end
  endtask

  task automatic test_multu_max();
    int edges, busy_cnt, stray;
    logic dbz;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cnt, dbz, stray);
    checks++; if (edges !== 33)          begin failures++; $display("FAIL multu_max_latency got=%0d exp=33", edges); end
    checks++; if (busy_cnt !== 33)       begin failures++; $display("FAIL multu_max_busy_cycles got=%0d exp=33", busy_cnt); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_max_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_max_lo got=%h exp=00000001", lo); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL multu_max_busy_done got=%b exp=0", busy); end
    checks++; if (dbz !== 1'b0)         begin failures++; $display("FAIL multu_max_dbz got=%b exp=0", dbz); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (done !== 1'b0)        begin failures++; $display("FAIL multu_max_done_width got=%b exp=0", done); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_max_hold got=%h exp=fffffffe", hi); end
  endtask

  task automatic test_multiply();
    logic [1:0]   t_op [5];
    logic [W-1:0] t_a  [5];
    logic [W-1:0] t_b  [5];
    logic [W-1:0] t_hi [5];
    logic [W-1:0] t_lo [5];
    int edges, busy_cnt, stray;
    logic dbz;
    t_op[0] = OP_MULT;  t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd7;          t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFEB;
    t_op[1] = OP_MULT;  t_a[1] = 32'hFFFF_FFFB; t_b[1] = 32'hFFFF_FFFA; t_hi[1] = 32'h0;         t_lo[1] = 32'd30;
    t_op[2] = OP_MULT;  t_a[2] = 32'h7FFF_FFFF; t_b[2] = 32'd2;          t_hi[2] = 32'h0;         t_lo[2] = 32'hFFFF_FFFE;
    t_op[3] = OP_MULTU; t_a[3] = 32'h8000_0000; t_b[3] = 32'd4;          t_hi[3] = 32'h2;         t_lo[3] = 32'h0;
    t_op[4] = OP_MULTU; t_a[4] = 32'h1234_5678; t_b[4] = 32'h10;         t_hi[4] = 32'h1;         t_lo[4] = 32'h2345_6780;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], edges, busy_cnt, dbz, stray);
      checks++; if (edges !== 33)    begin failures++; $display("FAIL mul%0d_latency got=%0d exp=33", i, edges); end
      checks++; if (hi !== t_hi[i]) begin failures++; $display("FAIL mul%0d_hi got=%h exp=%h", i, hi, t_hi[i]); end
      checks++; if (lo !== t_lo[i]) begin failures++; $display("FAIL mul%0d_lo got=%h exp=%h", i, lo, t_lo[i]); end
    end
  endtask

  task automatic test_divide();
    logic [1:0]   t_op [5];
    logic [W-1:0] t_a  [5];
    logic [W-1:0] t_b  [5];
    logic [W-1:0] t_hi [5];
    logic [W-1:0] t_lo [5];
    int edges, busy_cnt, stray;
    logic dbz;
    t_op[0] = OP_DIV;  t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;          t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFFD;
    t_op[1] = OP_DIV;  t_a[1] = 32'd7;          t_b[1] = 32'hFFFF_FFFE; t_hi[1] = 32'd1;         t_lo[1] = 32'hFFFF_FFFD;
    t_op[2] = OP_DIV;  t_a[2] = 32'hFFFF_FFF8; t_b[2] = 32'hFFFF_FFFD; t_hi[2] = 32'hFFFF_FFFE; t_lo[2] = 32'd2;
    t_op[3] = OP_DIVU; t_a[3] = 32'd100;        t_b[3] = 32'd7;          t_hi[3] = 32'd2;         t_lo[3] = 32'd14;
    t_op[4] = OP_DIVU; t_a[4] = 32'hFFFF_FFFF; t_b[4] = 32'h10;         t_hi[4] = 32'hF;         t_lo[4] = 32'h0FFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], edges, busy_cnt, dbz, stray);
      checks++; if (edges !== 33)    begin failures++; $display("FAIL div%0d_latency got=%0d exp=33", i, edges); end
      checks++; if (hi !== t_hi[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, t_hi[i]); end
      checks++; if (lo !== t_lo[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, t_lo[i]); end
      checks++; if (dbz !== 1'b0)    begin failures++; $display("FAIL div%0d_dbz got=%b exp=0", i, dbz); end
    end
  endtask

  task automatic test_div_by_zero();
    int edges, busy_cnt, stray;
    logic dbz;
    run_op(OP_DIVU, 32'd100, 32'd0, edges, busy_cnt, dbz, stray);
    checks++; if (edges !== 33)  begin failures++; $display("FAIL dbz_latency got=%0d exp=33", edges); end
    checks++; if (hi !== '0)     begin failures++; $display("FAIL dbz_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)     begin failures++; $display("FAIL dbz_lo got=%h exp=0", lo); end
    checks++; if (dbz !== 1'b1)  begin failures++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    checks++; if (stray !== 0)   begin failures++; $display("FAIL dbz_early got=%0d exp=0", stray); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_width got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div_overflow();
    int edges, busy_cnt, stray;
    logic dbz;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cnt, dbz, stray);
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0)         begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
    checks++; if (dbz !== 1'b0)         begin failures++; $display("FAIL div_ovf_dbz got=%b exp=0", dbz); end
  endtask

  task automatic test_concurrency();
    int edges, busy_cnt, stray;
    logic dbz;
    // MULTU 6*7 accepted on the same edge as an MTHI/MTLO write
    start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE_0001;
    @(posedge clock);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    @(negedge clock);
    checks++; if (hi !== 32'hCAFE_0001) begin failures++; $display("FAIL same_edge_mthi got=%h exp=cafe0001", hi); end
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL same_edge_busy got=%b exp=1", busy); end
    repeat (5) @(posedge clock);
    // RUN cycle 5: competing start and MTHI, both must be ignored
    @(negedge clock);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; hi_we = 1'b1; wd = 32'h1234;
    @(posedge clock);
    #1;
    start = 1'b0; hi_we = 1'b0; wd = '0;
    @(negedge clock);
    checks++; if (hi !== 32'hCAFE_0001) begin failures++; $display("FAIL busy_mthi_ignored got=%h exp=cafe0001", hi); end
    edges = 6;
    while (!done && edges < 100) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    checks++; if (edges !== 33)   begin failures++; $display("FAIL conc_latency got=%0d exp=33", edges); end
    checks++; if (hi !== 32'd0)   begin failures++; $display("FAIL conc_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd42)  begin failures++; $display("FAIL conc_lo got=%h exp=2a", lo); end
    // start in the done cycle is accepted
    run_op(OP_DIVU, 32'd9, 32'd3, edges, busy_cnt, dbz, stray);
    checks++; if (edges !== 33)   begin failures++; $display("FAIL done_cycle_start_latency got=%0d exp=33", edges); end
    checks++; if (lo !== 32'd3)   begin failures++; $display("FAIL done_cycle_start_lo got=%h exp=3", lo); end
    checks++; if (hi !== 32'd0)   begin failures++; $display("FAIL done_cycle_start_hi got=%h exp=0", hi); end
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    int hilo_nz;
    // leave nonzero HI/LO behind so the reset clear is visible
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0BAD_F00D;
    @(posedge clock);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clock);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (hi !== '0)     begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0)     begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    hilo_nz  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) done_cnt++;
      if (hi !== '0 || lo !== '0) hilo_nz++;
    end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++; if (hilo_nz !== 0)  begin failures++; $display("FAIL abort_hilo_zero got=%0d exp=0", hilo_nz); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu_max();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_div_overflow();
    test_concurrency();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width; verified only at 32.
REQ-002 clock  input  1  Rising-edge clock for all state.
REQ-003 reset  input  1  Reset, asynchronous, active-high.
REQ-004 start  input  1  Request a new operation; sampled only in IDLE.
REQ-005 op  input  2  Operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  Multiplicand or dividend, sampled with start.
REQ-007 b  input  WIDTH  Multiplier or divisor, sampled with start.
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wd  input  WIDTH  MTHI/MTLO write data.
REQ-011 busy  output  1  High whenever state is not IDLE; the hazard unit stalls on it.
REQ-012 done  output  1  One-cycle pulse, high in the cycle after HI/LO receive a result.
REQ-013 hi  output  WIDTH  Registered HI: product upper half or remainder.
REQ-014 lo  output  WIDTH  Registered LO: product lower half or quotient.
REQ-015 div_by_zero  output  1  Pulses with done when a DIV/DIVU had b == 0.

Function
REQ-016 FSM states: IDLE, RUN, FIN; busy = (state != IDLE).
REQ-017 IDLE -> RUN on a rising edge with start=1.
- At that edge, latch op, the operand magnitudes (absolute value for signed ops, raw value for unsigned ops), both operand signs, and the b==0 flag.
- Clear the iteration counter to 0.
REQ-018 RUN lasts exactly WIDTH cycles, one iteration per cycle, counter 0..WIDTH-1; RUN -> FIN on the edge where counter == WIDTH-1.
REQ-019 Multiply: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator; for MULT, negate the 2*WIDTH result in FIN when the operand signs differ.
REQ-020 Divide: radix-2 restoring division on magnitudes.
- DIV quotient sign = sign(a) XOR sign(b).
- DIV remainder sign = sign(a).
- -2^31 / -1 yields LO=0x80000000, HI=0x00000000 (wrap, no trap).
REQ-021 FIN -> IDLE on the next edge.
- That edge writes HI/LO: product {hi,lo}, or remainder->hi and quotient->lo.
- The following cycle has done=1, busy=0.
REQ-022 Latency: start sampled at edge E0, HI/LO updated at edge E(WIDTH+1), done high during the cycle after E(WIDTH+1); 33 edges at WIDTH=32.
REQ-023 Divide by zero:
- Runs the full latency.
- Writes HI=0 and LO=0.
- Sets div_by_zero=1 for the same cycle as done; div_by_zero is 0 at all other times.
REQ-024 start while busy=1 is ignored; there is no queueing and no error.
REQ-025 start in the done cycle (state IDLE) is accepted normally.
REQ-026 hi_we/lo_we in IDLE write wd to HI/LO at the edge; hi_we/lo_we while busy=1 are ignored.
REQ-027 hi_we/lo_we and start on the same IDLE edge: the write takes effect at that edge, the operation is accepted, and its result later overwrites HI/LO.
REQ-028 HI/LO hold their value at all times other than REQ-021, REQ-023 and REQ-026.
REQ-029 Operand inputs are don't-care except on the accepting edge; later changes do not affect the result.

Reset
REQ-030 reset=1 immediately forces state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0 and counter=0, independent of clock.
REQ-031 reset during RUN or FIN aborts the operation; no done pulse follows and HI/LO stay 0.
REQ-032 start is ignored while reset=1; the first accepted start is the first rising edge with reset=0 and start=1.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the start edge; busy high for 33 cycles.
REQ-034 MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100 b=0 -> hi=0, lo=0, div_by_zero=1 only in the done cycle; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 Concurrency:
- Start MULTU 6*7; at RUN cycle 5 pulse start (op=DIVU, a=9, b=3) and hi_we (wd=0x1234).
- Required: both ignored; result hi=0, lo=42.
- In the done cycle, start DIVU 9/3 -> accepted; lo=3, hi=0.
REQ-037 In IDLE, hi_we=1 lo_we=1 wd=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 next cycle, busy stays 0, no done.
REQ-038 reset pulsed asynchronously at RUN cycle 10 -> busy=0, hi=lo=0 immediately; no done for 40 cycles.
